// File: rtl/pwm_ramp_sequencer_if.sv
// pwm_ramp_sequencer_if: operator/command inputs and PWM command outputs.
// master drives commands (upstream/bench), slave is the sequencer.
interface pwm_ramp_sequencer_if;
  logic        button;
  logic        frame_start;
  logic [31:0] target_width;
  logic        target_load;
  logic [31:0] pulse_width;
  logic        pulse_valid;
  logic        armed;
  logic        running;

  modport master (
    output button, frame_start, target_width, target_load,
    input  pulse_width, pulse_valid, armed, running
  );

  modport slave (
    input  button, frame_start, target_width, target_load,
    output pulse_width, pulse_valid, armed, running
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: frame-synchronous arm/run/stop slew-limited PWM command.
// Optional PWM_RAMP_SWEEP_EN: in RUN the target sweeps MIN..MAX by STEP.
module pwm_ramp_sequencer #(
  parameter int unsigned NEUTRAL         = 75000,
  parameter int unsigned MIN_WIDTH       = 50000,
  parameter int unsigned MAX_WIDTH       = 100000,
  parameter int unsigned STEP            = 2000,
  parameter int unsigned ARM_FRAMES      = 50,
  parameter int unsigned RUN_FRAMES      = 250,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic                 clock,
  input logic                 reset,
  pwm_ramp_sequencer_if.slave bus
);

  localparam int unsigned FMAX =
    (ARM_FRAMES > RUN_FRAMES) ? ARM_FRAMES : RUN_FRAMES;
  localparam int FW = $clog2(FMAX + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic          btn_s1;
  logic          btn_s2;
  logic [CW-1:0] db_cnt;
  logic          press;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_n;
  logic [31:0]   width;
  logic [31:0]   width_n;
  logic [31:0]   target;
  logic [31:0]   target_n;
  logic          valid_q;
  logic          armed_q;
  logic          running_q;

  function automatic logic [31:0] slew(
    input logic [31:0] cur,
    input logic [31:0] tgt
  );
    if (cur < tgt)
      return (tgt - cur <= STEP) ? tgt : cur + STEP;
    else
      return (cur - tgt <= STEP) ? tgt : cur - STEP;
  endfunction

  function automatic logic [31:0] clamp(
    input logic [31:0] w
  );
    if (w < MIN_WIDTH)
      return MIN_WIDTH;
    else if (w > MAX_WIDTH)
      return MAX_WIDTH;
    else
      return w;
  endfunction

  // Fires on the cycle the D-th consecutive low sample is counted.
  assign press = !btn_s2 &&
    (db_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Synchronize the button and count consecutive low samples (saturating).
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      db_cnt <= '0;
    end else begin
      btn_s1 <= bus.button;
      btn_s2 <= btn_s1;
      if (btn_s2)
        db_cnt <= '0;
      else if (db_cnt != CW'(DEBOUNCE_CYCLES))
        db_cnt <= db_cnt + 1'b1;
    end
  end

  // Next state, frame count and width; a press outranks the frame step.
  always_comb begin
    state_n = state;
    frame_n = frame_cnt;
    width_n = width;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (press) begin
          state_n = S_ARM;
          frame_n = '0;
        end
      end
      (state == S_ARM): begin
        if (press) begin
          state_n = S_IDLE;
        end else if (bus.frame_start) begin
          if (frame_cnt == FW'(ARM_FRAMES - 1)) begin
            state_n = S_RUN;
            frame_n = '0;
          end else begin
            frame_n = frame_cnt + 1'b1;
          end
        end
      end
      (state == S_RUN): begin
        if (press) begin
          state_n = S_STOP;
          frame_n = '0;
        end else if (bus.frame_start) begin
          width_n = slew(width, target);
          if (frame_cnt == FW'(RUN_FRAMES - 1)) begin
            state_n = S_STOP;
            frame_n = '0;
          end else begin
            frame_n = frame_cnt + 1'b1;
          end
        end
      end
      default: begin
        if (bus.frame_start) begin
          if (width == NEUTRAL)
            state_n = S_IDLE;
          else
            width_n = slew(width, NEUTRAL);
        end
      end
    endcase
  end

  // Target register; the frame step above always sees the old value.
  always_comb begin
    target_n = target;
`ifdef PWM_RAMP_SWEEP_EN
    if (state == S_RUN) begin
      if (bus.frame_start)
        target_n = (target + STEP >= MAX_WIDTH) ?
          MIN_WIDTH : target + STEP;
    end else if (bus.target_load) begin
      target_n = clamp(bus.target_width);
    end
`else
    if (bus.target_load)
      target_n = clamp(bus.target_width);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      width     <= NEUTRAL;
      target    <= NEUTRAL;
      valid_q   <= 1'b0;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_n;
      width     <= width_n;
      target    <= target_n;
      valid_q   <= (state_n != S_IDLE);
      armed_q   <= (state_n == S_ARM);
      running_q <= (state_n == S_RUN);
    end
  end

  assign bus.pulse_width = width;
  assign bus.pulse_valid = valid_q;
  assign bus.armed       = armed_q;
  assign bus.running     = running_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model of the sequencer.
module tb_pwm_ramp_sequencer;

  localparam int unsigned NEU  = 75000;
  localparam int unsigned MINW = 50000;
  localparam int unsigned MAXW = 100000;
  localparam int unsigned STP  = 2000;
  localparam int unsigned ARMF = 3;
  localparam int unsigned RUNF = 10;
  localparam int unsigned DEB  = 4;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_STOP = 3;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  pwm_ramp_sequencer_if bus();

  pwm_ramp_sequencer #(
    .NEUTRAL(NEU), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW),
    .STEP(STP), .ARM_FRAMES(ARMF), .RUN_FRAMES(RUNF),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: button history, mode name, frames seen, widths.
  logic        m_s1, m_s2;
  int          m_low;
  int          m_mode;
  int          m_frames;
  int unsigned m_pw;
  int unsigned m_tgt;

  function automatic int unsigned m_slew(int unsigned cur,
                                         int unsigned tgt);
    int d;
    d = int'(tgt) - int'(cur);
    if (d > int'(STP)) return cur + STP;
    if (d < -int'(STP)) return cur - STP;
    return tgt;
  endfunction

  function automatic int unsigned m_clamp(logic [31:0] w);
    if (w < MINW) return MINW;
    if (w > MAXW) return MAXW;
    return w;
  endfunction

  initial begin
    bit          pr;
    int          old_mode;
    int unsigned old_tgt;
    m_s1 = 1; m_s2 = 1; m_low = 0;
    m_mode = M_IDLE; m_frames = 0;
    m_pw = NEU; m_tgt = NEU;
    @(posedge clock);
    forever begin
      @(negedge clock);
      chk("cyc_width", bus.pulse_width, m_pw);
      chk("cyc_valid", bus.pulse_valid, 32'(m_mode != M_IDLE));
      chk("cyc_armed", bus.armed, 32'(m_mode == M_ARM));
      chk("cyc_running", bus.running, 32'(m_mode == M_RUN));
      if (reset) begin
        m_s1 = 1; m_s2 = 1; m_low = 0;
        m_mode = M_IDLE; m_frames = 0;
        m_pw = NEU; m_tgt = NEU;
      end else begin
        m_low = m_s2 ? 0 : m_low + 1;
        pr = !m_s2 && (m_low == int'(DEB));
        m_s2 = m_s1;
        m_s1 = bus.button;
        old_mode = m_mode;
        old_tgt = m_tgt;
        case (old_mode)
          M_IDLE: if (pr) begin m_mode = M_ARM; m_frames = 0; end
          M_ARM: begin
            if (pr) m_mode = M_IDLE;
            else if (bus.frame_start) begin
              m_frames++;
              if (m_frames == int'(ARMF)) begin
                m_mode = M_RUN; m_frames = 0;
              end
            end
          end
          M_RUN: begin
            if (pr) m_mode = M_STOP;
            else if (bus.frame_start) begin
              m_pw = m_slew(m_pw, old_tgt);
              m_frames++;
              if (m_frames == int'(RUNF)) m_mode = M_STOP;
            end
          end
          default: begin
            if (bus.frame_start) begin
              if (m_pw == NEU) m_mode = M_IDLE;
              else m_pw = m_slew(m_pw, NEU);
            end
          end
        endcase
`ifdef PWM_RAMP_SWEEP_EN
        if (old_mode == M_RUN) begin
          if (bus.frame_start)
            m_tgt = (old_tgt + STP >= MAXW) ? MINW : old_tgt + STP;
        end else if (bus.target_load) begin
          m_tgt = m_clamp(bus.target_width);
        end
`else
        if (bus.target_load) m_tgt = m_clamp(bus.target_width);
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    tick(3);
  endtask

  task automatic load(input logic [31:0] w);
    bus.target_width = w;
    bus.target_load = 1'b1;
    tick(1);
    bus.target_load = 1'b0;
  endtask

  task automatic press();
    bus.button = 1'b0;
    tick(4);
    bus.button = 1'b1;
    tick(4);
  endtask

  task automatic chk_reset_vals();
    chk("rst_width", bus.pulse_width, 75000);
    chk("rst_valid", bus.pulse_valid, 0);
    chk("rst_armed", bus.armed, 0);
    chk("rst_running", bus.running, 0);
  endtask

  initial begin
    int  tog;
    logic [31:0] edge_w [6];
    edge_w = '{32'd0, 32'd49999, 32'd50000,
               32'd100000, 32'd100001, 32'hFFFF_FFFF};
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.button = 1'b1;
    bus.frame_start = 1'b0;
    bus.target_width = '0;
    bus.target_load = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_reset_vals();

    bus.button = 1'b0;
    tick(3);
    bus.button = 1'b1;
    tick(8);
    chk("glitch_armed", bus.armed, 0);
    chk("glitch_valid", bus.pulse_valid, 0);

    bus.button = 1'b0;
    tick(4);
    bus.button = 1'b1;
    tick(1);
    chk("press5_armed", bus.armed, 0);
    tick(1);
    chk("press6_armed", bus.armed, 1);
    chk("arm_valid", bus.pulse_valid, 1);
    chk("arm_width", bus.pulse_width, 75000);

    frame();
    frame();
    chk("arm2_armed", bus.armed, 1);
    frame();
    chk("run_running", bus.running, 1);
    chk("run_armed", bus.armed, 0);

    load(81000);
    frame(); chk("run_f1", bus.pulse_width, 77000);
    frame(); chk("run_f2", bus.pulse_width, 79000);
    frame(); chk("run_f3", bus.pulse_width, 81000);
    frame(); chk("run_f4", bus.pulse_width, 81000);
    load(120000);
    frame(); chk("run_f5", bus.pulse_width, 83000);
    load(30000);
    frame(); chk("run_f6", bus.pulse_width, 81000);
    frame(); chk("run_f7", bus.pulse_width, 79000);
    load(81000);
    frame(); chk("run_f8", bus.pulse_width, 81000);
    frame(); chk("run_f9_running", bus.running, 1);
    frame();
    chk("f10_running", bus.running, 0);
    chk("f10_valid", bus.pulse_valid, 1);
    chk("f10_width", bus.pulse_width, 81000);
    frame(); chk("stop_1", bus.pulse_width, 79000);
    frame(); chk("stop_2", bus.pulse_width, 77000);
    frame(); chk("stop_3", bus.pulse_width, 75000);
    chk("stop_3_valid", bus.pulse_valid, 1);
    frame();
    chk("idle_valid", bus.pulse_valid, 0);
    chk("idle_width", bus.pulse_width, 75000);

    press();
    chk("s2_armed", bus.armed, 1);
    frame(); frame(); frame();
    chk("s2_running", bus.running, 1);
    load(90000);
    frame(); chk("s2_f1", bus.pulse_width, 77000);
    bus.button = 1'b0;
    tick(4);
    bus.button = 1'b1;
    tick(1);
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    chk("pf_running", bus.running, 0);
    chk("pf_valid", bus.pulse_valid, 1);
    chk("pf_width", bus.pulse_width, 77000);
    reset = 1'b1;
    tick(1);
    chk_reset_vals();
    reset = 1'b0;
    tick(2);

    for (int blk = 0; blk < 8; blk++) begin
      tog = blk[0] ? 8 : 200;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, tog - 1) == 0)
          bus.button = ~bus.button;
        bus.frame_start = ($urandom_range(0, 7) == 0);
        bus.target_load = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0)
          bus.target_width = edge_w[$urandom_range(0, 5)];
        else
          bus.target_width = $urandom_range(40000, 110000);
        reset = ($urandom_range(0, 699) == 0);
        tick(1);
      end
    end
    reset = 1'b0;
    bus.frame_start = 1'b0;
    bus.target_load = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Command stage directly upstream of the servo/ESC PWM generator. Turns an operator button and a target pulse-width command into a frame-synchronous, slew-limited pulse-width value (in 20 ns clock cycles) for the PWM generator. It sequences arm, run, timed run-out and controlled ramp-down back to neutral. All updates are aligned to the generator's 20 ms frame boundary.

## Interface
Parameters:
- NEUTRAL, 75000: idle/arming pulse width in cycles (1500 us).
- MIN_WIDTH, 50000: lower clamp for any commanded width (1000 us).
- MAX_WIDTH, 100000: upper clamp (2000 us).
- STEP, 2000: maximum width change per frame.
- ARM_FRAMES, 50: frames held at NEUTRAL before run (1 s).
- RUN_FRAMES, 250: frames in RUN before automatic stop (5 s).
- DEBOUNCE_CYCLES, 1000000: consecutive low samples that qualify a press (20 ms).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- button  in  1  operator button, active-low, asynchronous to logic; double-registered internally.
- frame_start  in  1  one-cycle pulse from the PWM generator at each period start.
- target_width  in  32  requested pulse width in cycles.
- target_load  in  1  one-cycle strobe; captures target_width.
- pulse_width  out  32  width for the PWM generator.
- pulse_valid  out  1  high when the generator should drive pulses; low means hold the output low.
- armed  out  1  high in ARM.
- running  out  1  high in RUN.

## Operation
- Reset values: pulse_width=NEUTRAL, pulse_valid=0, armed=0, running=0. The internal target resets to NEUTRAL. Frame and debounce counters reset to 0. State resets to IDLE.
- Debounce: the counter increments while the synchronized button is low and clears while it is high. A press event fires once when the count reaches DEBOUNCE_CYCLES. No further event fires until the button has been seen high.
- target_load: target = clamp(target_width, MIN_WIDTH, MAX_WIDTH), registered. It is accepted in every state.
- States:
  - IDLE: pulse_valid=0, pulse_width=NEUTRAL. A press moves to ARM and clears the frame counter.
  - ARM: pulse_valid=1, pulse_width=NEUTRAL. Each frame_start increments the frame counter. When the counter reaches ARM_FRAMES, the state moves to RUN and the counter clears. A press moves to IDLE (abort).
  - RUN: on each frame_start, pulse_width steps toward the target.
    - If the difference is at most STEP, pulse_width becomes the target.
    - Otherwise it moves by exactly STEP in the direction of the target.
    - The frame counter increments on each frame_start. Reaching RUN_FRAMES, or a press, moves the state to STOP.
  - STOP: pulse_valid=1. On each frame_start, pulse_width steps toward NEUTRAL using the same slew rule. On the first frame_start at which pulse_width already equals NEUTRAL, the state moves to IDLE.
- Arithmetic: unsigned 32-bit. Compare before subtracting, so no operation wraps.
- Outputs are registered. All four outputs change only on clock edges.

## Timing
- pulse_width changes one cycle after the frame_start that triggers the step. The generator therefore latches the new value at the next frame.
- State transitions take effect on the cycle after the triggering event.
- A press event fires DEBOUNCE_CYCLES+2 cycles after button falls, including the 2-cycle synchronizer.
- target_load coincident with frame_start: that frame's step uses the old target; the new target applies from the next frame.
- Press coincident with frame_start:
  - In RUN: the press wins; the state goes to STOP and no RUN step occurs that frame.
  - In ARM: the press wins; the state goes to IDLE.
- Reset asserted mid-operation: all outputs return to reset values on the next edge, regardless of state.

## Configuration
- PWM_RAMP_SWEEP_EN defined: in RUN, target_load is ignored. On each frame_start the target advances by STEP. When the result would be at or above MAX_WIDTH, it reloads MIN_WIDTH. This is a bench sweep mode.
- Not defined: the target comes only from target_load. No sweep logic is present.

## Test plan
Use NEUTRAL=75000, STEP=2000, DEBOUNCE_CYCLES=4, ARM_FRAMES=3, RUN_FRAMES=10.
- Reset, then idle: pulse_valid=0, pulse_width=75000, armed=0, running=0.
- Glitch of 3 low cycles, then 4-cycle press: the glitch gives no transition; the press gives armed=1 at press+6 cycles. After 3 frame_start pulses, running=1 and armed=0.
- In RUN, load 81000: widths over successive frames are 77000, 79000, 81000, then 81000 held. Loading 120000 clamps the target to 100000.
- Load 30000 in RUN: the target clamps to 50000. The width ramps down by 2000 per frame.
- At frame 10 with width 81000: STOP ramps 79000, 77000, 75000. The next frame_start gives IDLE with pulse_valid=0.
- Press during RUN coincident with frame_start: enters STOP with no RUN step that frame. Reset asserted mid-STOP returns all outputs to reset values one cycle later.
